// File: rtl/mul_seq_ctrl_if.sv
// Handshake bundle for mul_seq_ctrl: execute-stage request/response, stall and
// error flags, plus the port pair that drives the iterative multiplier core.
// The controller sits on the slave modport; the execute stage / core side is master.
interface mul_seq_ctrl_if;
    // Execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        flush;

    // Result handshake and status
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        busy;
    logic        err;

    // Multiplier core
    logic        mul_valid;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        mul_done;
    logic [63:0] mul_c;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, resp_ready, mul_done, mul_c,
        output req_ready, resp_valid, resp_data, busy, err, mul_valid, mul_a, mul_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush, resp_ready, mul_done, mul_c,
        input  req_ready, resp_valid, resp_data, busy, err, mul_valid, mul_a, mul_b
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer between the execute stage and an iterative multiplier core.
// Accepts one MUL/MULW at a time, holds operands on the core until it reports done,
// returns the (optionally sign-extended) low product, and handles pipeline flushes
// and a watchdog that aborts a hung core with a sticky error.
module mul_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input logic           clk,
    input logic           resetn,
    mul_seq_ctrl_if.slave bus
);

    localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);
    // Count value held during the last permitted BUSY/DRAIN cycle.
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHold,
        StDrain
    } state_e;

    state_e              state_q;
    logic                op_q;
    logic [63:0]         a_q;
    logic [63:0]         b_q;
    logic [63:0]         resp_q;
    logic [WdWidth-1:0]  wd_q;
    logic                first_q;
    logic                err_q;
    logic                done_seen;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // A done pulse in the first cycle after acceptance may be left over from the
    // core's previous op, so it is masked. DRAIN is only ever entered after that
    // cycle, so a completion arriving right after a flush is never lost.
    assign done_seen = bus.mul_done && !first_q;

    // Control FSM, operand/result latches, watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            resp_q  <= '0;
            wd_q    <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid && !bus.flush) begin
                        op_q    <= bus.req_op;
                        a_q     <= bus.req_op ? sext32(bus.req_a[31:0]) : bus.req_a;
                        b_q     <= bus.req_op ? sext32(bus.req_b[31:0]) : bus.req_b;
                        wd_q    <= '0;
                        first_q <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    first_q <= 1'b0;
                    wd_q    <= wd_q + WdWidth'(1);
                    if (done_seen) begin
                        if (bus.flush) begin
                            state_q <= StIdle;
                        end else begin
                            resp_q  <= op_q ? sext32(bus.mul_c[31:0]) : bus.mul_c;
                            state_q <= StHold;
                        end
                    end else if (wd_q == WdLast) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (bus.flush) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    first_q <= 1'b0;
                    wd_q    <= wd_q + WdWidth'(1);
                    if (done_seen) begin
                        state_q <= StIdle;
                    end else if (wd_q == WdLast) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StHold: begin
                    if (bus.flush || bus.resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are straight decodes of registered state, so they carry no input paths.
    assign bus.req_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.resp_valid = (state_q == StHold);
    assign bus.mul_valid  = (state_q == StBusy) || (state_q == StDrain);
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.resp_data  = resp_q;
    assign bus.err        = err_q;

endmodule
